// File: rtl/program_loader.sv
// Boot-time program loader: parses a byte stream (16-bit word count, 4*N
// little-endian instruction bytes, XOR checksum) and writes each word into
// instruction memory while holding the core in reset until the load is verified.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   in_valid, in_byte      byte-stream source
//   in_ready               loader accepts a byte this cycle
//   imem_we/addr/wdata     one-cycle instruction-memory write per word
//   core_reset             holds the core in reset until the load is verified
//   done, err              sticky load-complete / load-failed flags
module program_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;
    // Words-remaining counter must be able to hold MAX_WORDS itself.
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic                word_last;
    logic [15:0]         count;
    logic [7:0]          count_lo;
    logic [1:0]          byte_cnt;
    logic [CNT_W-1:0]    words_left;
    logic [ADDR_W-1:0]   word_index;
    logic [23:0]         word_buf;
    logic [7:0]          checksum;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; only an accepted byte moves the FSM.
    always_comb begin
        next_state = state;
        accept     = in_valid && in_ready;
        word_last  = (byte_cnt == 2'd3);
        count      = {in_byte, count_lo};
        if (accept) begin
            case (state)
                HDR0: next_state = HDR1;
                HDR1: begin
                    if (count == 16'd0) begin
                        next_state = CSUM;
                    end else if (32'(count) > MAX_WORDS) begin
                        next_state = ERR;
                    end else begin
                        next_state = DATA;
                    end
                end
                DATA: begin
                    if (word_last && (words_left == CNT_W'(1))) begin
                        next_state = CSUM;
                    end
                end
                CSUM: next_state = (in_byte == checksum) ? DONE : ERR;
                default: next_state = state;
            endcase
        end
    end

    // Datapath and registered outputs; flags follow the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            count_lo   <= 8'd0;
            byte_cnt   <= 2'd0;
            words_left <= CNT_W'(0);
            word_index <= ADDR_W'(0);
            word_buf   <= 24'd0;
            checksum   <= 8'd0;
        end else begin
            imem_we    <= 1'b0;
            in_ready   <= (next_state inside {HDR0, HDR1, DATA, CSUM});
            done       <= (next_state == DONE);
            err        <= (next_state == ERR);
            core_reset <= (next_state != DONE);
            if (accept) begin
                case (state)
                    HDR0: count_lo <= in_byte;
                    HDR1: words_left <= CNT_W'(count);
                    DATA: begin
                        checksum <= checksum ^ in_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_last) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= 32'({word_index, 2'b00});
                            imem_wdata <= {in_byte, word_buf};
                            word_index <= word_index + ADDR_W'(1);
                            words_left <= words_left - CNT_W'(1);
                        end else begin
                            // Bytes arrive LSB first; shift down so b0 ends in [7:0].
                            word_buf <= {in_byte, word_buf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  stim_q[$];
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic        exp_done;
    logic        exp_err;
    int          consumed;
    logic        overlap = 1'b0;

    typedef struct packed {
        logic [7:0]   len;
        logic [127:0] b;     // byte i at b[8*i +: 8]
        logic [7:0]   nwr;
        logic [31:0]  w0;
        logic         done;
        logic         err;
    } vec_t;

    vec_t vecs [6];

    // Write monitor: every imem_we cycle is one write.
    always @(negedge clk) begin
        if (imem_we) begin
            got_q.push_back({imem_addr, imem_wdata});
            if (done) overlap = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        got_q.delete();
        overlap = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    // Reference model: parse the stream by its framing rules.
    task automatic model_stream();
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        n = int'({stim_q[1], stim_q[0]});
        if (n > int'(MAX_WORDS)) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            consumed = 2;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = {stim_q[2+4*i+3], stim_q[2+4*i+2], stim_q[2+4*i+1], stim_q[2+4*i]};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            exp_q.push_back({32'(i * 4), w});
        end
        exp_done = (stim_q[2+4*n] == x);
        exp_err  = !exp_done;
        consumed = 3 + 4 * n;
    endtask

    task automatic run_stream(input string tag);
        int m;
        model_stream();
        for (int i = 0; i < consumed; i++) send_byte(stim_q[i], $urandom_range(0, 3));
        check({tag, ".done"}, 64'(done), 64'(exp_done));
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        check({tag, ".core_reset"}, 64'(core_reset), 64'(!exp_done));
        tick();
        tick();
        check({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        check({tag, ".nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({tag, ".write"}, got_q[i], exp_q[i]);
        check({tag, ".we_with_done"}, 64'(overlap), 64'd0);
    endtask

    task automatic gen_random();
        int kind;
        int n;
        logic [7:0] x;
        logic [7:0] b;
        stim_q.delete();
        kind = $urandom_range(0, 9);
        if (kind == 0) n = 0;
        else if (kind == 1) n = 257 + $urandom_range(0, 1000);
        else n = $urandom_range(1, 6);
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
        if (n > int'(MAX_WORDS)) return;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            stim_q.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
        stim_q.push_back(x);
    endtask

    task automatic load_vec(input vec_t v);
        logic [127:0] bb;
        bb = v.b;
        stim_q.delete();
        for (int i = 0; i < int'(v.len); i++) stim_q.push_back(bb[8*i +: 8]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{len: 8'd7,  b: 128'hC3_00_50_00_93_00_01, nwr: 8'd1, w0: 32'h00500093, done: 1'b1, err: 1'b0};
        vecs[1] = '{len: 8'd7,  b: 128'hC2_00_50_00_93_00_01, nwr: 8'd1, w0: 32'h00500093, done: 1'b0, err: 1'b1};
        vecs[2] = '{len: 8'd3,  b: 128'h00_00_00,             nwr: 8'd0, w0: 32'h0,        done: 1'b1, err: 1'b0};
        vecs[3] = '{len: 8'd2,  b: 128'h01_01,                nwr: 8'd0, w0: 32'h0,        done: 1'b0, err: 1'b1};
        vecs[4] = '{len: 8'd11, b: 128'h71_00_A0_01_13_00_50_00_93_00_02,
                    nwr: 8'd2, w0: 32'h00500093, done: 1'b1, err: 1'b0};
        vecs[5] = '{len: 8'd3,  b: 128'h01_00_00,             nwr: 8'd0, w0: 32'h0,        done: 1'b0, err: 1'b1};

        // Reset values, and ready on the first cycle after release.
        reset = 1'b1;
        tick();
        tick();
        check("rst.imem_we", 64'(imem_we), 64'd0);
        check("rst.imem_addr", 64'(imem_addr), 64'd0);
        check("rst.imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst.core_reset", 64'(core_reset), 64'd1);
        check("rst.done", 64'(done), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        reset = 1'b0;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        got_q.delete();

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            load_vec(vecs[v]);
            run_stream($sformatf("vec%0d", v));
            check($sformatf("vec%0d.tbl_nwr", v), 64'(got_q.size()), 64'(vecs[v].nwr));
            check($sformatf("vec%0d.tbl_done", v), 64'(done), 64'(vecs[v].done));
            check($sformatf("vec%0d.tbl_err", v), 64'(err), 64'(vecs[v].err));
            if (vecs[v].nwr != 8'd0) begin
                if (got_q.size() > 0)
                    check($sformatf("vec%0d.tbl_w0", v), 64'(got_q[0][31:0]), 64'(vecs[v].w0));
                check($sformatf("vec%0d.hold_wdata", v), 64'(imem_wdata), 64'(exp_q[exp_q.size()-1][31:0]));
                check($sformatf("vec%0d.hold_addr", v), 64'(imem_addr), 64'(exp_q[exp_q.size()-1][63:32]));
            end
        end

        // Reset after two word bytes, then the full stream.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 1);
        send_byte(8'h93, 0);
        send_byte(8'h00, 2);
        do_reset();
        check("midrst.imem_addr", 64'(imem_addr), 64'd0);
        load_vec(vecs[0]);
        run_stream("midrst");

        // Reset on the same edge as the 4th word byte cancels the write.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h00;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("cancel.nwrites", 64'(got_q.size()), 64'd0);
        check("cancel.in_ready", 64'(in_ready), 64'd1);
        load_vec(vecs[0]);
        run_stream("cancel");

        // Full-capacity load: last address must be (MAX_WORDS-1)*4.
        do_reset();
        begin
            logic [7:0] x;
            logic [7:0] b;
            stim_q.delete();
            stim_q.push_back(8'h00);
            stim_q.push_back(8'h01);
            x = 8'h00;
            for (int i = 0; i < 4 * int'(MAX_WORDS); i++) begin
                b = 8'($urandom);
                x = x ^ b;
                stim_q.push_back(b);
            end
            stim_q.push_back(x);
        end
        run_stream("max");
        check("max.last_addr", 64'(imem_addr), 64'h3FC);

        // Randomized streams against the reference model.
        for (int r = 0; r < 25; r++) begin
            do_reset();
            gen_random();
            run_stream($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  byte-stream source has a byte on in_byte.
REQ-005 SHALL have port in_byte  input  8  load-stream byte.
REQ-006 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-007 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 SHALL have port imem_addr  output  32  byte address of the word being written (word_index*4, PC-compatible).
REQ-009 SHALL have port imem_wdata  output  32  instruction word being written.
REQ-010 SHALL have port core_reset  output  1  holds the single-cycle core (PC, register file, data memory) in reset while high.
REQ-011 SHALL have port done  output  1  load completed and verified; sticky.
REQ-012 SHALL have port err  output  1  load failed; sticky.

Function
REQ-013 SHALL accept a byte only on a rising edge where in_valid and in_ready are both 1; in_byte SHALL be ignored otherwise, and in_valid may deassert between any two bytes.
REQ-014 SHALL parse the stream as: count low byte, count high byte (N, 16-bit), then 4*N word bytes little-endian (first byte = bits 7:0), then 1 checksum byte.
REQ-015 SHALL implement states HDR0, HDR1, DATA, CSUM, DONE, ERR; in_ready = 1 in HDR0/HDR1/DATA/CSUM and 0 in DONE/ERR.
REQ-016 HDR0 -> HDR1 on byte accept; HDR1 -> DATA on accept if 1 <= N <= MAX_WORDS, -> CSUM if N = 0, -> ERR if N > MAX_WORDS.
REQ-017 SHALL track bytes within the word (0..3) and words remaining; DATA -> CSUM on acceptance of the final (4*N-th) word byte.
REQ-018 SHALL, on acceptance of the 4th byte of a word, drive imem_we = 1 for exactly the next cycle with imem_addr = word_index*4 and imem_wdata = {b3,b2,b1,b0}; write latency is 1 cycle.
REQ-019 SHALL start word_index at 0, increment it by 1 after each write, and write at most MAX_WORDS words; imem_addr SHALL never exceed (MAX_WORDS-1)*4.
REQ-020 SHALL hold imem_addr and imem_wdata at their last values when imem_we = 0.
REQ-021 SHALL compute checksum as the 8-bit XOR of all word bytes only (header excluded), initialised to 0x00.
REQ-022 CSUM -> DONE on accept when the received byte equals the running checksum, else -> ERR.
REQ-023 SHALL, from the cycle after entering DONE onward, drive done = 1 and core_reset = 0; DONE and ERR are left only by reset.
REQ-024 SHALL, in ERR, drive err = 1, core_reset = 1, in_ready = 0, imem_we = 0.
REQ-025 SHALL never drive imem_we in the same cycle as done = 1; the final word write always precedes done by at least 1 cycle.
REQ-026 SHALL keep core_reset = 1 in every state other than DONE.

Reset
REQ-027 SHALL, while reset is high at a rising edge, enter HDR0 and set imem_we = 0, imem_addr = 0, imem_wdata = 0, core_reset = 1, done = 0, err = 0, word_index = 0, checksum = 0x00, byte counter = 0.
REQ-028 SHALL treat reset mid-load as dominant: any partially assembled word is discarded, a write pending for the next cycle is cancelled, and a new stream begins with the count bytes.
REQ-029 SHALL drive in_ready = 1 the first cycle after reset deasserts.

Verification
REQ-030 Reset, send 01 00 93 00 50 00 C3 -> one imem_we pulse, addr 0x00000000, data 0x00500093; then done = 1, core_reset = 0, err = 0.
REQ-031 N = 2, words 0x00500093 and 0x00A00113 with random in_valid gaps, correct checksum -> writes at addr 0x0 and 0x4 in order, done = 1.
REQ-032 Stream of REQ-030 with checksum 0xC2 -> err = 1, core_reset = 1, in_ready = 0, done = 0.
REQ-033 Send 00 00 00 -> no imem_we, done = 1, core_reset = 0.
REQ-034 ADDR_W = 8, send 01 01 (N = 257) -> err = 1 the cycle after the second byte, no imem_we.
REQ-035 Assert reset after 2 word bytes of the REQ-030 stream, then replay the full REQ-030 stream -> no write of the partial word, single write addr 0x0 data 0x00500093, done = 1.
